// File: rtl/mem_req_dispatch.sv
// mem_req_dispatch: steers physically addressed CPU requests to the cached or
// uncached downstream port and returns responses strictly in request order.
// Only one target may have requests outstanding at a time; a request to the
// other target waits until every outstanding response has come back.
//
// Handshake: a request transfers on a cycle where *_req and *_addr_ok are
// both high (address phase). A response transfers on a cycle where *_data_ok
// is high (data phase, no back-pressure). Every accepted request, read or
// write, produces exactly one data_ok, and responses come back in
// acceptance order.
module mem_req_dispatch #(
  parameter int unsigned MAX_OUT = 2,
  localparam int CW = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_size,
  input  logic [31:0]   cpu_addr,
  input  logic          cpu_uncached,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_addr_ok,
  output logic          cpu_data_ok,
  output logic [31:0]   cpu_rdata,
  // cached port
  output logic          cache_req,
  output logic          cache_wr,
  output logic [1:0]    cache_size,
  output logic [31:0]   cache_addr,
  output logic [31:0]   cache_wdata,
  input  logic          cache_addr_ok,
  input  logic          cache_data_ok,
  input  logic [31:0]   cache_rdata,
  // uncached port
  output logic          uc_req,
  output logic          uc_wr,
  output logic [1:0]    uc_size,
  output logic [31:0]   uc_addr,
  output logic [31:0]   uc_wdata,
  input  logic          uc_addr_ok,
  input  logic          uc_data_ok,
  input  logic [31:0]   uc_rdata,
  // state visibility
  output logic [CW-1:0] dbg_cnt,
  output logic          dbg_cur_tgt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cur_tgt_q, cur_tgt_d;

  logic tgt;
  logic allow;
  logic acc;
  logic ret;

  // Payload goes to both ports; only the req strobe selects the target.
  assign cache_wr    = cpu_wr;
  assign cache_size  = cpu_size;
  assign cache_addr  = cpu_addr;
  assign cache_wdata = cpu_wdata;
  assign uc_wr       = cpu_wr;
  assign uc_size     = cpu_size;
  assign uc_addr     = cpu_addr;
  assign uc_wdata    = cpu_wdata;

  assign dbg_cnt     = cnt_q;
  assign dbg_cur_tgt = cur_tgt_q;

  // Request steering, response selection and outstanding-count next state.
  always_comb begin
    tgt         = cpu_uncached;
    // Accept only when idle, or when staying on the current target with room.
    // Uses registered count so a return never frees a slot in its own cycle.
    allow       = (cnt_q == '0) || ((tgt == cur_tgt_q) && (cnt_q < CW'(MAX_OUT)));
    cache_req   = cpu_req & allow & ~tgt;
    uc_req      = cpu_req & allow & tgt;
    cpu_addr_ok = cpu_req & allow & (tgt ? uc_addr_ok : cache_addr_ok);
    acc         = cpu_addr_ok;

    // data_ok from the idle port, or while nothing is outstanding, is dropped.
    ret         = (cnt_q != '0) & (cur_tgt_q ? uc_data_ok : cache_data_ok);
    cpu_data_ok = ret;
    cpu_rdata   = '0;
    if (ret) begin
      cpu_rdata = cur_tgt_q ? uc_rdata : cache_rdata;
    end

    cnt_d = cnt_q;
    case ({acc, ret})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    cur_tgt_d = cur_tgt_q;
    if (acc && (cnt_q == '0)) begin
      cur_tgt_d = tgt;
    end
  end

  // Outstanding count and current target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_tgt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_tgt_q <= cur_tgt_d;
    end
  end

endmodule

// File: tb/tb_mem_req_dispatch.sv
// tb_mem_req_dispatch: directed scenarios followed by random traffic. The bench
// plays both downstream ports; each accepted request pushes a response token
// onto exp_q, and the token is compared when cpu_data_ok returns.
module tb_mem_req_dispatch;

  localparam int unsigned MAX_OUT = 2;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_wr, cpu_uncached;
  logic [1:0]    cpu_size;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_addr_ok, cpu_data_ok;
  logic [31:0]   cpu_rdata;
  logic          cache_req, cache_wr;
  logic [1:0]    cache_size;
  logic [31:0]   cache_addr, cache_wdata;
  logic          cache_addr_ok, cache_data_ok;
  logic [31:0]   cache_rdata;
  logic          uc_req, uc_wr;
  logic [1:0]    uc_size;
  logic [31:0]   uc_addr, uc_wdata;
  logic          uc_addr_ok, uc_data_ok;
  logic [31:0]   uc_rdata;
  logic [CW-1:0] dbg_cnt;
  logic          dbg_cur_tgt;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: response tokens in acceptance order, plus the expected target
  logic [31:0] exp_q[$];
  logic        m_tgt;

  mem_req_dispatch #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_uncached(cpu_uncached), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .cache_req(cache_req), .cache_wr(cache_wr), .cache_size(cache_size),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok), .cache_rdata(cache_rdata),
    .uc_req(uc_req), .uc_wr(uc_wr), .uc_size(uc_size),
    .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_addr_ok(uc_addr_ok), .uc_data_ok(uc_data_ok), .uc_rdata(uc_rdata),
    .dbg_cnt(dbg_cnt), .dbg_cur_tgt(dbg_cur_tgt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    cache_addr_ok = 1'b0; cache_data_ok = 1'b0;
    uc_addr_ok = 1'b0; uc_data_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_tgt = 1'b0;
  endtask

  // One clock cycle: drive CPU and downstream inputs, check every output
  // against the scoreboard's view, then advance the scoreboard at the edge.
  task automatic run_cycle(input logic req, input logic unc, input logic [31:0] addr,
                           input logic c_aok, input logic c_dok,
                           input logic u_aok, input logic u_dok,
                           input logic [31:0] tok);
    int          tot;
    logic        allow, e_acc, e_ret;
    logic [31:0] front;
    @(negedge clk);
    cpu_req       = req;
    cpu_uncached  = unc;
    cpu_addr      = addr;
    cpu_wr        = 1'($urandom_range(0, 1));
    cpu_size      = 2'($urandom_range(0, 2));
    cpu_wdata     = $urandom;
    cache_addr_ok = c_aok;
    cache_data_ok = c_dok;
    uc_addr_ok    = u_aok;
    uc_data_ok    = u_dok;
    tot   = exp_q.size();
    front = (tot != 0) ? exp_q[0] : 32'h0;
    e_ret = (tot != 0) && (m_tgt ? u_dok : c_dok);
    cache_rdata = (e_ret && !m_tgt) ? front : $urandom;
    uc_rdata    = (e_ret &&  m_tgt) ? front : $urandom;
    allow = (tot == 0) || ((unc == m_tgt) && (tot < int'(MAX_OUT)));
    e_acc = req && allow && (unc ? u_aok : c_aok);
    #2;
    check_eq("cnt",        32'(dbg_cnt), 32'(tot));
    check_eq("cur_tgt",    32'(dbg_cur_tgt), 32'(m_tgt));
    check_eq("cache_req",  32'(cache_req), 32'(req && allow && !unc));
    check_eq("uc_req",     32'(uc_req), 32'(req && allow && unc));
    check_eq("addr_ok",    32'(cpu_addr_ok), 32'(e_acc));
    check_eq("data_ok",    32'(cpu_data_ok), 32'(e_ret));
    check_eq("cache_addr", cache_addr, addr);
    check_eq("uc_wdata",   uc_wdata, cpu_wdata);
    check_eq("uc_size",    32'(uc_size), 32'(cpu_size));
    check_eq("cache_wr",   32'(cache_wr), 32'(cpu_wr));
    if (e_ret) check_eq("rdata", cpu_rdata, exp_q.pop_front());
    else       check_eq("rdata_idle", cpu_rdata, 32'h0);
    @(posedge clk);
    if (e_acc) begin
      if (tot == 0) m_tgt = unc;
      exp_q.push_back(tok);
    end
  endtask

  task automatic peek_state(input string tag, input int exp_cnt, input logic exp_tgt);
    @(negedge clk);
    cpu_req = 1'b0; cache_data_ok = 1'b0; uc_data_ok = 1'b0;
    #2;
    check_eq({tag, "_cnt"}, 32'(dbg_cnt), 32'(exp_cnt));
    check_eq({tag, "_tgt"}, 32'(dbg_cur_tgt), 32'(exp_tgt));
  endtask

  initial begin
    logic unc_r;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = '0;
    cpu_uncached = 1'b0; cpu_wdata = '0;
    cache_addr_ok = 1'b0; cache_data_ok = 1'b0; cache_rdata = '0;
    uc_addr_ok = 1'b0; uc_data_ok = 1'b0; uc_rdata = '0;
    m_tgt = 1'b0;
    do_reset();

    // reset state
    peek_state("reset", 0, 1'b0);
    check_eq("reset_addr_ok", 32'(cpu_addr_ok), 32'h0);
    check_eq("reset_data_ok", 32'(cpu_data_ok), 32'h0);

    // uncached read at boot address, then its response
    run_cycle(1, 1, 32'h1FC0_0000, 0, 0, 1, 0, 32'hDEAD_BEEF);
    peek_state("uc1", 1, 1'b1);
    run_cycle(0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
    check_eq("uc1_rdata_const", cpu_rdata, 32'hDEAD_BEEF);
    peek_state("uc1_done", 0, 1'b1);

    // fill to MAX_OUT on cached port, third waits until a return frees a slot
    do_reset();
    run_cycle(1, 0, 32'h0000_1000, 1, 0, 0, 0, 32'h1111_0001);
    run_cycle(1, 0, 32'h0000_1004, 1, 0, 0, 0, 32'h1111_0002);
    run_cycle(1, 0, 32'h0000_1008, 1, 0, 0, 0, 32'h1111_0003);
    check_eq("full_blocked", 32'(cache_req), 32'h0);
    run_cycle(1, 0, 32'h0000_1008, 1, 1, 0, 0, 32'h1111_0003);
    check_eq("full_ret_no_acc", 32'(cpu_addr_ok), 32'h0);
    run_cycle(1, 0, 32'h0000_1008, 1, 0, 0, 0, 32'h1111_0003);
    check_eq("full_acc_after", 32'(cpu_addr_ok), 32'h1);
    run_cycle(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    run_cycle(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    peek_state("full_done", 0, 1'b0);

    // target switch: uncached held until cached drains, then accepted next cycle
    run_cycle(1, 0, 32'h0000_2000, 1, 0, 0, 0, 32'h2222_0001);
    run_cycle(1, 1, 32'h1FD0_0000, 0, 0, 1, 0, 32'h2222_0002);
    run_cycle(1, 1, 32'h1FD0_0000, 0, 1, 1, 0, 32'h2222_0002);
    check_eq("switch_same_cycle_uc_req", 32'(uc_req), 32'h0);
    run_cycle(1, 1, 32'h1FD0_0000, 0, 0, 1, 0, 32'h2222_0002);
    check_eq("switch_uc_req", 32'(uc_req), 32'h1);
    peek_state("switch", 1, 1'b1);
    run_cycle(0, 0, 32'h0, 0, 0, 0, 1, 32'h0);

    // same-cycle accept and return on cached port with one outstanding
    run_cycle(1, 0, 32'h0000_3000, 1, 0, 0, 0, 32'h3333_0001);
    run_cycle(1, 0, 32'h0000_3004, 1, 1, 0, 0, 32'h3333_0002);
    check_eq("acc_ret_both", 32'(cpu_addr_ok & cpu_data_ok), 32'h1);
    peek_state("acc_ret", 1, 1'b0);

    // spurious uncached data_ok while cached is current
    run_cycle(0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
    check_eq("spurious_data_ok", 32'(cpu_data_ok), 32'h0);
    peek_state("spurious", 1, 1'b0);

    // reset with two outstanding; late data_ok ignored; uncached accepted at once
    run_cycle(1, 0, 32'h0000_4000, 1, 0, 0, 0, 32'h4444_0001);
    peek_state("pre_rst", 2, 1'b0);
    do_reset();
    peek_state("post_rst", 0, 1'b0);
    run_cycle(0, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    check_eq("late_data_ok", 32'(cpu_data_ok), 32'h0);
    run_cycle(1, 1, 32'h1FC0_0010, 0, 0, 1, 0, 32'h5555_0001);
    check_eq("post_rst_uc_acc", 32'(cpu_addr_ok), 32'h1);
    run_cycle(0, 0, 32'h0, 0, 0, 0, 1, 32'h0);

    // random traffic with random handshakes and spurious data_ok
    unc_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) unc_r = ~unc_r;
      run_cycle(1'($urandom_range(0, 9) < 7), unc_r, $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                $urandom);
    end

    // drain whatever remains
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, 0, 32'h0, 0, 1, 0, 1, 32'h0);
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'h0);
    peek_state("end", 0, m_tgt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_dispatch.md
# mem_req_dispatch

Memory-side dispatcher for data/instruction accesses that have already been translated to a physical address with an uncached flag. Accepts one sram-like request stream from the CPU side and steers each request to the cached port or the uncached port. Tracks outstanding requests so that responses return to the CPU strictly in request order. Sits between the address-translation stage and the cache / AXI bridge.

## Interface
- MAX_OUT, 2, maximum outstanding (address-accepted, data-not-returned) requests; range 1..7
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU request valid
- cpu_wr  in  1  1 = write, 0 = read
- cpu_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_addr  in  32  physical address
- cpu_uncached  in  1  1 = route to uncached port
- cpu_wdata  in  32  write data
- cpu_addr_ok  out  1  request accepted this cycle
- cpu_data_ok  out  1  response for oldest outstanding request
- cpu_rdata  out  32  read data, valid with cpu_data_ok
- cache_req / uc_req  out  1  downstream request valid
- cache_wr, cache_size, cache_addr, cache_wdata / uc_ (same widths)  out  pass-through of CPU fields
- cache_addr_ok / uc_addr_ok  in  1  downstream accepted request
- cache_data_ok / uc_data_ok  in  1  downstream response
- cache_rdata / uc_rdata  in  32  downstream read data

## Operation
- State: cnt (outstanding count, width clog2(MAX_OUT+1)), cur_tgt (0 = cached, 1 = uncached).
- tgt = cpu_uncached. allow = (cnt == 0) || (tgt == cur_tgt && cnt < MAX_OUT).
- cache_req = cpu_req & allow & ~tgt; uc_req = cpu_req & allow & tgt. Payload fields drive both ports unconditionally.
- cpu_addr_ok = allow & (tgt ? uc_addr_ok : cache_addr_ok) & cpu_req.
- Accept (acc) = cpu_req & cpu_addr_ok. On acc with cnt == 0, cur_tgt <= tgt.
- Return (ret) = (cnt != 0) & (cur_tgt ? uc_data_ok : cache_data_ok). cpu_data_ok = ret; cpu_rdata = cur_tgt ? uc_rdata : cache_rdata; cpu_rdata is don't-care when ret = 0 and is driven with 0 in that case.
- cnt update: acc & ~ret -> +1; ret & ~acc -> -1; both or neither -> hold.
- Target switch: a request to the other target is held (req low to both ports, addr_ok = 0) until cnt reaches 0; it may be accepted in the same cycle the last return occurs only if cnt == 0 at that cycle start (no same-cycle bypass).
- data_ok from the non-current port, or from any port with cnt == 0, is ignored (not forwarded, cnt unchanged).
- Write responses count identically to reads.

## Timing
- Reset: cnt = 0, cur_tgt = 0; hence cpu_addr_ok = 0 and cpu_data_ok = 0 until inputs request; all downstream req low while cpu_req low.
- Request path is combinational: CPU request to downstream req zero cycles; addr_ok returns same cycle.
- Response path is combinational: downstream data_ok to cpu_data_ok zero cycles.
- Minimum turnaround when switching target: one cycle after the final return of the old target.
- Full: cnt == MAX_OUT blocks acceptance; a return in that cycle frees the slot for the next cycle, not the current one.
- Reset mid-operation: cnt cleared; late downstream data_ok after reset is ignored per the cnt == 0 rule.

## Test plan
- Reset, then cpu_req with addr 0x1FC0_0000, uncached = 1, uc_addr_ok = 1 -> uc_req = 1, cache_req = 0, cpu_addr_ok = 1; next cycle cnt = 1, cur_tgt = 1; uc_data_ok with rdata 0xDEAD_BEEF -> cpu_data_ok = 1, cpu_rdata = 0xDEAD_BEEF, cnt = 0.
- MAX_OUT = 2: three back-to-back cached reads with cache_addr_ok held 1, no data_ok -> first two accepted, third has cache_req = 0 and cpu_addr_ok = 0 until a cache_data_ok arrives; it is accepted the cycle after.
- One cached read outstanding, then uncached request -> uc_req low until cache_data_ok returns; uc_req high the following cycle; cur_tgt flips to 1.
- Same-cycle accept and return on the same target with cnt = 1 -> cnt stays 1, cpu_addr_ok and cpu_data_ok both 1.
- Spurious uc_data_ok while cur_tgt = 0 and cnt = 1 -> cpu_data_ok = 0, cnt stays 1.
- Assert rst with cnt = 2 -> next cycle cnt = 0; subsequent cache_data_ok is not forwarded; new uncached request is accepted immediately.
